lsu: RTL

- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus store data and access size.
- Runs a single-outstanding req/ack transaction on the data-memory port.
- Returns an aligned, sign/zero-extended load word for writeback; stalls the core via busy until done.

---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_align.sv | 33 +++
 rtl/lsu.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, FSM state encodings and timeout counter width for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] MEM_SIZE_B   = 2'b00;
  localparam logic [1:0] MEM_SIZE_H   = 2'b01;
  localparam logic [1:0] MEM_SIZE_W   = 2'b10;
  localparam logic [1:0] MEM_SIZE_BAD = 2'b11;
  localparam int LSU_TIMEOUT_W = 16;
  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_RESP = 2'd2
  } lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane strobes, store-data replication, load extraction/extension and misalignment check.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic            unsigned_ld,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_val,
  output logic            misaligned
);
  logic [XLEN-1:0] sh;
  logic [7:0]      b;
  logic [15:0]     h;
  always_comb begin
    sh = mem_rdata >> {offset, 3'b000};
    b = sh[7:0];
    h = sh[15:0];
    misaligned = (size == MEM_SIZE_BAD) || (size == MEM_SIZE_H && offset[0]) ||
                 (size == MEM_SIZE_W && offset != 2'b00);
    wstrb = size == MEM_SIZE_B ? 4'b0001 << offset :
            size == MEM_SIZE_H ? 4'b0011 << offset : 4'b1111;
    wdata_rep = size == MEM_SIZE_B ? {(XLEN/8){wdata[7:0]}} :
                size == MEM_SIZE_H ? {(XLEN/16){wdata[15:0]}} : wdata;
    load_val = size == MEM_SIZE_B ? {{(XLEN-8){~unsigned_ld & b[7]}}, b} :
               size == MEM_SIZE_H ? {{(XLEN-16){~unsigned_ld & h[15]}}, h} : mem_rdata;
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit on a req/ack data-memory port.
// Optional ack timeout with bus_fault reporting is enabled by defining LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [1:0]      size,
  input  logic            unsigned_ld,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic            bus_fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);
  lsu_state_t      state;
  logic [1:0]      r_size, r_off, a_size, a_off;
  logic            r_uns, a_uns, a_mis;
  logic [3:0]      a_wstrb;
  logic [XLEN-1:0] a_wdata, a_load;
  // In IDLE the aligner sees the new request; afterwards it sees the latched access for load extraction.
  assign a_size = state == LSU_ST_IDLE ? size : r_size;
  assign a_off  = state == LSU_ST_IDLE ? addr[1:0] : r_off;
  assign a_uns  = state == LSU_ST_IDLE ? unsigned_ld : r_uns;
  lsu_align #(.XLEN(XLEN)) u_align (
    .size(a_size), .offset(a_off), .unsigned_ld(a_uns), .wdata(wdata), .mem_rdata(mem_rdata),
    .wstrb(a_wstrb), .wdata_rep(a_wdata), .load_val(a_load), .misaligned(a_mis)
  );
`ifdef LSU_TIMEOUT_EN
  logic [LSU_TIMEOUT_W-1:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign bus_fault = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LSU_ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rdata <= '0;
      misaligned <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      r_size <= '0;
      r_off <= '0;
      r_uns <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_fault <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_fault <= 1'b0;
`endif
      case (state)
        LSU_ST_IDLE: if (start) begin
          busy <= 1'b1;
          if (a_mis) begin
            state <= LSU_ST_RESP;
            done <= 1'b1;
            misaligned <= 1'b1;
          end else begin
            state <= LSU_ST_REQ;
            mem_req <= 1'b1;
            mem_we <= is_store;
            mem_addr <= {addr[XLEN-1:2], 2'b00};
            mem_wdata <= a_wdata;
            mem_wstrb <= is_store ? a_wstrb : 4'b0000;
            r_size <= size;
            r_off <= addr[1:0];
            r_uns <= unsigned_ld;
`ifdef LSU_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        LSU_ST_REQ: begin
          if (mem_ack) begin
            state <= LSU_ST_RESP;
            mem_req <= 1'b0;
            done <= 1'b1;
            if (!mem_we) rdata <= a_load;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == LSU_TIMEOUT_W'(TIMEOUT_CYCLES)) begin
            state <= LSU_ST_RESP;
            mem_req <= 1'b0;
            done <= 1'b1;
            bus_fault <= 1'b1;
          end else cnt <= cnt + 1'b1;
`endif
        end
        default: begin
          state <= LSU_ST_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
